// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between the core and a DMA loader using bounded DMA bursts.
// Optional perf counters are built only when ARB_PERF_CNT_EN is defined.
module dmem_port_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_last,
  input  logic [63:0] dma_addr,
  input  logic [63:0] dma_wdata,
  output logic        dma_gnt,
  output logic [63:0] dma_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [63:0] mem_rdata,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_dma_beats
);
  localparam logic [1:0] CPU_OWN  = 2'd0;
  localparam logic [1:0] DMA_OWN  = 2'd1;
  localparam logic [1:0] CPU_TURN = 2'd2;
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic dma_own, cap_hit;
  assign dma_own = state_q == DMA_OWN;
  assign cnt_inc = cnt_q + 8'd1;
  assign cap_hit = cnt_inc == 8'(MAX_BURST);
  // Only a continuing, unfinished burst stays with the DMA; CPU_TURN behaves like CPU_OWN for its one cycle.
  always_comb begin
    state_d = (dma_req && !dma_own) ? DMA_OWN : CPU_OWN;
    cnt_d = 8'd0;
    if (dma_own && dma_req && !dma_last) begin
      state_d = cap_hit ? CPU_TURN : DMA_OWN;
      cnt_d = cap_hit ? 8'd0 : cnt_inc;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CPU_OWN;
      cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign dma_gnt   = dma_own;
  assign cpu_stall = dma_own & cpu_req;
  assign mem_addr  = dma_own ? dma_addr : cpu_addr;
  assign mem_wdata = dma_own ? dma_wdata : cpu_wdata;
  assign mem_we    = dma_own ? (dma_req & dma_we) : (cpu_req & cpu_we);
  assign mem_re    = dma_own ? (dma_req & ~dma_we) : (cpu_req & ~cpu_we);
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_q, beats_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 32'd0;
      beats_q <= 32'd0;
    end else begin
      if (cpu_stall && ~&stall_q) stall_q <= stall_q + 32'd1;
      if (dma_own && dma_req && ~&beats_q) beats_q <= beats_q + 32'd1;
    end
  end
  assign perf_stall_cycles = stall_q;
  assign perf_dma_beats    = beats_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_dma_beats    = 32'd0;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed test-plan scenarios plus random traffic checked against a behavioural ownership model.
module tb_dmem_port_arbiter;
  localparam int MAXB = 8;
`ifdef ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, cpu_stall;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic dma_req, dma_we, dma_last, dma_gnt;
  logic [63:0] dma_addr, dma_wdata, dma_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_we, mem_re;
  logic [31:0] perf_stall_cycles, perf_dma_beats;
  int n_cmp = 0;
  int n_err = 0;
  bit m_dma;
  int m_run;
  logic [31:0] m_stall, m_beats;
  logic [31:0] pat;
  int cyc;

  dmem_port_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .perf_stall_cycles(perf_stall_cycles), .perf_dma_beats(perf_dma_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Compare every output against what the ownership model says for the current inputs.
  task automatic settle();
    #1;
    chk("gnt", dma_gnt, m_dma);
    chk("stall", cpu_stall, m_dma && cpu_req);
    chk("mem_we", mem_we, m_dma ? (dma_req && dma_we) : (cpu_req && cpu_we));
    chk("mem_re", mem_re, m_dma ? (dma_req && !dma_we) : (cpu_req && !cpu_we));
    chk("mem_addr", mem_addr, m_dma ? dma_addr : cpu_addr);
    chk("mem_wdata", mem_wdata, m_dma ? dma_wdata : cpu_wdata);
    chk("cpu_rdata", cpu_rdata, mem_rdata);
    chk("dma_rdata", dma_rdata, mem_rdata);
    chk("perf_stall", perf_stall_cycles, PERF ? m_stall : 32'd0);
    chk("perf_beats", perf_dma_beats, PERF ? m_beats : 32'd0);
  endtask

  // Model: DMA owns the port after any cycle it asked while not owning; it keeps it for a run of
  // consecutive beats until it stops asking, flags its last beat, or has used MAXB beats.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_dma = 1'b0; m_run = 0; m_stall = 32'd0; m_beats = 32'd0;
    end else begin
      if (m_dma && cpu_req && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (m_dma && dma_req && m_beats != 32'hFFFF_FFFF) m_beats = m_beats + 32'd1;
      if (!m_dma) begin
        m_dma = dma_req; m_run = 0;
      end else if (!dma_req || dma_last) begin
        m_dma = 1'b0; m_run = 0;
      end else begin
        m_run = m_run + 1;
        if (m_run == MAXB) begin m_dma = 1'b0; m_run = 0; end
      end
    end
    #1;
  endtask

  task automatic dma_burst(input int n, input logic [63:0] base, output logic [31:0] p, output int c);
    int i;
    i = 0; p = 32'd0; c = 0;
    dma_we = 1'b1;
    while (i < n && c < 200) begin
      dma_req = 1'b1;
      dma_addr = base + 64'(8 * i);
      dma_wdata = base ^ 64'(i * 3 + 1);
      dma_last = (i == n - 1);
      settle();
      p = {p[30:0], dma_gnt};
      if (dma_gnt) begin
        chk("burst_addr", mem_addr, base + 64'(8 * i));
        chk("burst_we", mem_we, 1'b1);
        i++;
      end
      tick();
      c++;
    end
    if (i < n) chk("burst_timeout", 64'(i), 64'(n));
    dma_req = 1'b0; dma_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_last = 1'b0; dma_addr = 64'd0; dma_wdata = 64'd0;
    mem_rdata = 64'd0;
    m_dma = 1'b0; m_run = 0; m_stall = 32'd0; m_beats = 32'd0;
    tick();
    cpu_req = 1'b1;
    settle();
    chk("rst_gnt", dma_gnt, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_perf_s", perf_stall_cycles, 32'd0);
    chk("rst_perf_b", perf_dma_beats, 32'd0);
    tick();
    // Core load passes straight through.
    reset = 1'b0; cpu_addr = 64'h10; mem_rdata = 64'hDEAD;
    settle();
    chk("t1_rdata", cpu_rdata, 64'hDEAD);
    chk("t1_re", mem_re, 1'b1);
    chk("t1_addr", mem_addr, 64'h10);
    chk("t1_stall", cpu_stall, 1'b0);
    chk("t1_gnt", dma_gnt, 1'b0);
    tick();
    cpu_req = 1'b0;
    // Three-beat DMA write ending on dma_last.
    dma_burst(3, 64'h0, pat, cyc);
    chk("t2_pat", pat, 32'b0111);
    chk("t2_cyc", 64'(cyc), 64'd4);
    settle();
    chk("t2_back", dma_gnt, 1'b0);
    tick();
    // 20-beat write against a storing core: capped bursts with a forced core slot between them.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h300; cpu_wdata = 64'hBAD;
    dma_burst(20, 64'h1000, pat, cyc);
    chk("t3_pat", pat, {9'd0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 4'hF});
    chk("t3_cyc", 64'(cyc), 64'd23);
    cpu_req = 1'b0; cpu_we = 1'b0;
    settle();
    tick();
    // Simultaneous requests: core store first, DMA beat next cycle.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h20; cpu_wdata = 64'h55;
    dma_req = 1'b1; dma_we = 1'b1; dma_last = 1'b1; dma_addr = 64'h100; dma_wdata = 64'h77;
    settle();
    chk("t4_core_addr", mem_addr, 64'h20);
    chk("t4_core_data", mem_wdata, 64'h55);
    chk("t4_core_we", mem_we, 1'b1);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    settle();
    chk("t4_dma_gnt", dma_gnt, 1'b1);
    chk("t4_dma_addr", mem_addr, 64'h100);
    chk("t4_dma_data", mem_wdata, 64'h77);
    chk("t4_dma_we", mem_we, 1'b1);
    tick();
    dma_req = 1'b0; dma_last = 1'b0;
    settle();
    tick();
    // Reset on beat 4 of an 8-beat burst.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h2000;
    settle();
    tick();
    repeat (3) begin
      settle();
      chk("t5_gnt", dma_gnt, 1'b1);
      tick();
      dma_addr = dma_addr + 64'd8;
    end
    reset = 1'b1;
    settle();
    chk("t5_inflight_we", mem_we, 1'b1);
    chk("t5_inflight_addr", mem_addr, 64'h2018);
    tick();
    reset = 1'b0;
    settle();
    chk("t5_after_rst", dma_gnt, 1'b0);
    tick();
    settle();
    chk("t5_regrant", dma_gnt, 1'b1);
    tick();
    dma_req = 1'b0;
    settle();
    tick();
    // Perf counters from reset: five beats, core waiting on each.
    reset = 1'b1;
    settle();
    tick();
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h40;
    dma_burst(5, 64'h3000, pat, cyc);
    settle();
    chk("t6_beats", perf_dma_beats, PERF ? 32'd5 : 32'd0);
    chk("t6_stalls", perf_stall_cycles, PERF ? 32'd5 : 32'd0);
    tick();
    // Random traffic.
    repeat (600) begin
      reset = ($urandom_range(99) < 2);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = {$urandom, $urandom}; cpu_wdata = {$urandom, $urandom};
      dma_req = ($urandom_range(9) < 7); dma_we = 1'($urandom);
      dma_last = ($urandom_range(19) == 0);
      dma_addr = {$urandom, $urandom}; dma_wdata = {$urandom, $urandom};
      mem_rdata = {$urandom, $urandom};
      settle();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single data-memory port between the single-cycle core's load/store path and a DMA loader that fills or dumps data memory, for example when preloading the array under sort. It sits between the core's ALU-result/MemRead/MemWrite signals and the Data_Memory instance. Core accesses pass through in the same cycle when the core owns the port. DMA transfers are granted as bounded bursts, and the core is held via a stall signal while the DMA owns the port.

## Interface
- MAX_BURST, default 8: maximum DMA beats per grant before the core gets a forced slot; legal range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  core memory access this cycle (MemRead | MemWrite).
- cpu_we  in  1  core access is a write.
- cpu_addr  in  64  core byte address (ALU result).
- cpu_wdata  in  64  core store data.
- cpu_rdata  out  64  load data to the core.
- cpu_stall  out  1  core must hold PC and suppress RegWrite this cycle.
- dma_req  in  1  DMA beat request.
- dma_we  in  1  DMA beat is a write.
- dma_last  in  1  current beat is the final beat of the transfer.
- dma_addr  in  64  DMA byte address.
- dma_wdata  in  64  DMA write data.
- dma_gnt  out  1  DMA owns the port; the beat completes this cycle if dma_req=1.
- dma_rdata  out  64  read data for a DMA read beat.
- mem_addr, mem_wdata  out  64  to the memory port.
- mem_we, mem_re  out  1  to the memory port.
- mem_rdata  in  64  from the memory port (combinational read).
- perf_stall_cycles  out  32  see Configuration.
- perf_dma_beats  out  32  see Configuration.

## Operation
- States: CPU_OWN, DMA_OWN, CPU_TURN. State encoding is registered; port muxing and stall are combinational from the state.
- CPU_OWN: memory port driven by the core (mem_we=cpu_req&cpu_we, mem_re=cpu_req&~cpu_we); dma_gnt=0; cpu_stall=0.
  - If dma_req=1, next state is DMA_OWN. The core access in this cycle still completes.
- DMA_OWN: memory port driven by DMA (mem_we=dma_req&dma_we, mem_re=dma_req&~dma_we); dma_gnt=1; cpu_stall=cpu_req; core writes never reach memory.
  - A beat is any cycle in which dma_req=1. The beat counter increments per beat.
  - If dma_req=0, next state is CPU_OWN (burst abandoned; counter cleared).
  - If the beat has dma_last=1, next state is CPU_OWN and the counter is cleared.
  - Otherwise, if this beat is beat number MAX_BURST, next state is CPU_TURN and the counter is cleared.
  - dma_last takes precedence over the MAX_BURST cap.
- CPU_TURN: port muxing as in CPU_OWN; dma_gnt=0. Lasts exactly one cycle whether or not cpu_req is high.
  - Next state is DMA_OWN if dma_req=1, otherwise CPU_OWN.
- cpu_rdata=mem_rdata and dma_rdata=mem_rdata at all times. Each is meaningful only when its owner is issuing a read.
- When no access occurs, mem_addr and mem_wdata follow the current owner's inputs; mem_we=mem_re=0.
- Beat counter width: 8 bits.

## Timing
- Core path: zero latency, purely combinational in CPU_OWN and CPU_TURN.
- DMA grant latency: dma_req rising in CPU_OWN yields dma_gnt=1 on the next cycle. DMA holds dma_req, address and data until it sees dma_gnt=1.
- DMA read data is valid in the same cycle as the granted read beat.
- Reset values: state CPU_OWN, beat counter 0, dma_gnt=0, cpu_stall=0, perf counters 0.
- Reset mid-burst returns to CPU_OWN at the next edge; the in-flight beat in the reset cycle still reaches memory.
- Simultaneous cpu_req and dma_req in CPU_OWN: the core wins this cycle and the DMA wins from the next cycle.
- Worst-case core stall is MAX_BURST consecutive cycles, guaranteed by CPU_TURN.

## Configuration
- ARB_PERF_CNT_EN defined:
  - perf_stall_cycles increments on every cycle with cpu_stall=1.
  - perf_dma_beats increments on every granted DMA beat.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- ARB_PERF_CNT_EN undefined: no counter registers are built; both perf outputs are tied to 0.

## Test plan
- Reset, then core load with cpu_addr=0x10 and mem_rdata=0xDEAD -> same-cycle cpu_rdata=0xDEAD, mem_re=1, cpu_stall=0, dma_gnt=0.
- dma_req held in CPU_OWN with 3 write beats, last beat tagged dma_last, addresses 0x0/0x8/0x10 -> dma_gnt=1 on cycles 2-4, three mem_we pulses with the DMA addresses, CPU_OWN on cycle 5.
- With MAX_BURST=8, a continuous 20-beat DMA write while cpu_req=1 -> grant pattern of 8 beats, 1 core slot, 8 beats, 1 core slot, 4 beats; cpu_stall=1 only on DMA cycles; no core write reaches memory during DMA cycles.
- Simultaneous cpu_req (store 0x55 to 0x20) and dma_req in CPU_OWN -> the core store commits this cycle and the DMA beat commits next cycle.
- Reset asserted on beat 4 of an 8-beat burst -> dma_gnt=0 and state CPU_OWN from the next cycle; a fresh dma_req is granted again after one cycle.
- With ARB_PERF_CNT_EN: a 5-beat DMA burst with cpu_req held -> perf_dma_beats=5, perf_stall_cycles=5. Without the macro, both read 0.
